// File: rtl/serial_paralelo.sv
`default_nettype none
// ============================================================================
// Module  : serial_paralelo
// Brief   : MSB-first serial-to-byte receiver with COM alignment and lock.
// Rev     : 1.0  initial release
// ============================================================================
module serial_paralelo #(
  parameter logic [7:0]  COM     = 8'hBC,
  parameter logic [7:0]  IDLE    = 8'h7C,
  parameter int unsigned BC_LOCK = 4
) (
  input  logic       clk16f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out_c,
  output logic       valid_out_c,
  output logic       active,
  output logic       byte_strobe
);

  localparam logic [3:0] C_BC_LOCK = 4'(BC_LOCK);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_ALIGN  = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  state_t     r_st;
  state_t     w_st_nxt;
  logic [6:0] r_sr;
  logic [2:0] r_bit_cnt;
  logic [3:0] r_bc_cnt;
  logic [3:0] w_bc_nxt;
  logic [7:0] w_cand;
  logic       w_boundary;
  logic       w_is_com;
  logic       w_payload;
  logic       w_emit;
  logic       w_lock;
  logic       w_realign;

  assign w_cand     = {r_sr, data_in};
  assign w_boundary = (r_bit_cnt == 3'd7);
  assign w_is_com   = (w_cand == COM);
  assign w_payload  = (w_cand != COM) && (w_cand != IDLE);

  always_comb begin
    w_st_nxt  = r_st;
    w_bc_nxt  = r_bc_cnt;
    w_emit    = 1'b0;
    w_lock    = 1'b0;
    w_realign = 1'b0;
    case (r_st)
      ST_SEARCH: begin
        if (w_is_com) begin
          w_st_nxt  = ST_ALIGN;
          w_bc_nxt  = 4'd1;
          w_realign = 1'b1;
        end
      end
      ST_ALIGN: begin
        // Only boundary-aligned COMs count; off-phase matches are ignored here.
        if (w_boundary) begin
          if (w_is_com) begin
            if (r_bc_cnt >= C_BC_LOCK) begin
              w_bc_nxt = C_BC_LOCK;
            end else begin
              w_bc_nxt = r_bc_cnt + 4'd1;
            end
            if (r_bc_cnt + 4'd1 >= C_BC_LOCK) begin
              w_st_nxt = ST_ACTIVE;
              w_lock   = 1'b1;
            end
          end else begin
            w_st_nxt = ST_SEARCH;
            w_bc_nxt = 4'd0;
          end
        end
      end
      ST_ACTIVE: begin
        w_emit = w_boundary;
      end
      default: begin
        w_st_nxt = ST_SEARCH;
        w_bc_nxt = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk16f or posedge reset) begin
    if (reset) begin
      r_st        <= ST_SEARCH;
      r_sr        <= 7'd0;
      r_bit_cnt   <= 3'd0;
      r_bc_cnt    <= 4'd0;
      data_out_c  <= 8'd0;
      valid_out_c <= 1'b0;
      active      <= 1'b0;
      byte_strobe <= 1'b0;
    end else begin
      r_st        <= w_st_nxt;
      r_sr        <= w_cand[6:0];
      r_bc_cnt    <= w_bc_nxt;
      r_bit_cnt   <= w_realign ? 3'd0 : r_bit_cnt + 3'd1;
      byte_strobe <= w_emit;
      if (w_emit) begin
        data_out_c  <= w_cand;
        valid_out_c <= w_payload;
      end
      if (w_lock) begin
        active <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_paralelo.sv
`default_nettype none
// ============================================================================
// Module  : tb_serial_paralelo
// Brief   : Directed + randomized bench for serial_paralelo with a bit-history model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_serial_paralelo;

  localparam logic [7:0] C_COM  = 8'hBC;
  localparam logic [7:0] C_IDLE = 8'h7C;
  localparam int         C_LOCK = 4;

  logic       clk16f = 1'b0;
  logic       reset  = 1'b1;
  logic       data_in = 1'b0;
  logic [7:0] data_out_c;
  logic       valid_out_c;
  logic       active;
  logic       byte_strobe;

  int checks   = 0;
  int failures = 0;
  int n_strobe = 0;

  // Model: history window of the last 7 bits plus the edge index of the
  // alignment anchor; byte boundaries are every 8th edge after the anchor.
  bit         m_q[$];
  int         m_mode;   // 0 search, 1 align, 2 active
  int         m_anchor;
  int         m_run;
  int         m_t;
  logic [7:0] e_data;
  logic       e_valid, e_active, e_strobe;

  serial_paralelo #(.COM(C_COM), .IDLE(C_IDLE), .BC_LOCK(C_LOCK)) dut (
    .clk16f      (clk16f),
    .reset       (reset),
    .data_in     (data_in),
    .data_out_c  (data_out_c),
    .valid_out_c (valid_out_c),
    .active      (active),
    .byte_strobe (byte_strobe)
  );

  always #5 clk16f = ~clk16f;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_q.delete();
    repeat (7) m_q.push_back(1'b0);
    m_mode = 0; m_run = 0; m_t = 0; m_anchor = 0;
    e_data = 8'd0; e_valid = 1'b0; e_active = 1'b0; e_strobe = 1'b0;
  endfunction

  function automatic void model_step(input bit b);
    logic [7:0] cand;
    bit         at_bnd;
    m_q.push_back(b);
    cand = 8'd0;
    for (int k = 0; k < 8; k++) cand = 8'(cand * 2 + int'(m_q[k]));
    void'(m_q.pop_front());
    e_strobe = 1'b0;
    at_bnd = (m_t > m_anchor) && (((m_t - m_anchor) % 8) == 0);
    if (m_mode == 0) begin
      if (cand == C_COM) begin
        m_mode = 1; m_anchor = m_t; m_run = 1;
      end
    end else if (m_mode == 1) begin
      if (at_bnd) begin
        if (cand == C_COM) begin
          m_run++;
          if (m_run == C_LOCK) begin
            m_mode = 2; e_active = 1'b1;
          end
        end else begin
          m_mode = 0; m_run = 0;
        end
      end
    end else if (at_bnd) begin
      e_data = cand; e_strobe = 1'b1;
      e_valid = (cand != C_COM) && (cand != C_IDLE);
    end
    m_t++;
  endfunction

  task automatic check_all();
    check("data_out_c", data_out_c, e_data);
    check("valid_out_c", 8'(valid_out_c), 8'(e_valid));
    check("active", 8'(active), 8'(e_active));
    check("byte_strobe", 8'(byte_strobe), 8'(e_strobe));
  endtask

  task automatic send_bit(input bit b);
    data_in = b;
    @(posedge clk16f);
    model_step(b);
    #1;
    if (byte_strobe === 1'b1) n_strobe++;
    check_all();
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    data_in = 1'b0;
    @(posedge clk16f);
    @(posedge clk16f);
    @(negedge clk16f);
    reset = 1'b0;
    model_reset();
    #1;
    check_all();
  endtask

  initial begin
    logic [7:0] rb;
    int         sel;
    model_reset();

    // 1: three COMs then a non-COM never lock
    do_reset();
    n_strobe = 0;
    repeat (3) send_byte(C_COM);
    send_byte(8'h55);
    send_byte(8'h00);
    check("t1_active", 8'(active), 8'd0);
    check("t1_strobes", 8'(n_strobe), 8'd0);

    // 2: four COMs lock; following bytes emitted
    do_reset();
    n_strobe = 0;
    repeat (3) send_byte(C_COM);
    send_byte(C_COM);
    check("t2_active_at_lock", 8'(active), 8'd1);
    check("t2_lock_no_strobe", 8'(byte_strobe), 8'd0);
    check("t2_lock_valid", 8'(valid_out_c), 8'd0);
    send_byte(8'h12);
    check("t2_data0", data_out_c, 8'h12);
    check("t2_valid0", 8'(valid_out_c), 8'd1);
    send_byte(8'h34);
    check("t2_data1", data_out_c, 8'h34);
    check("t2_strobes", 8'(n_strobe), 8'd2);

    // 3: COM/IDLE are shown but not valid
    send_byte(8'hA5);
    check("t3_valid_a5", 8'(valid_out_c), 8'd1);
    send_byte(C_IDLE);
    check("t3_data_7c", data_out_c, C_IDLE);
    check("t3_valid_7c", 8'(valid_out_c), 8'd0);
    send_byte(C_COM);
    check("t3_valid_bc", 8'(valid_out_c), 8'd0);
    send_byte(8'h3C);
    check("t3_data_3c", data_out_c, 8'h3C);
    check("t3_valid_3c", 8'(valid_out_c), 8'd1);

    // 4: misaligned stream
    do_reset();
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    repeat (4) send_byte(C_COM);
    send_byte(8'hF0);
    check("t4_active", 8'(active), 8'd1);
    check("t4_data", data_out_c, 8'hF0);
    check("t4_valid", 8'(valid_out_c), 8'd1);

    // 5: asynchronous reset mid-byte while active
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    #2;
    reset = 1'b1;
    #1;
    check("t5_async_data", data_out_c, 8'd0);
    check("t5_async_valid", 8'(valid_out_c), 8'd0);
    check("t5_async_active", 8'(active), 8'd0);
    check("t5_async_strobe", 8'(byte_strobe), 8'd0);
    @(posedge clk16f);
    @(posedge clk16f);
    @(negedge clk16f);
    reset = 1'b0;
    model_reset();
    repeat (3) send_byte(C_COM);
    check("t5_relock_3", 8'(active), 8'd0);
    send_byte(C_COM);
    check("t5_relock_4", 8'(active), 8'd1);

    // 6: unaligned COM window inside 0x5E 0x3F
    do_reset();
    n_strobe = 0;
    send_byte(8'h5E);
    send_byte(8'h3F);
    repeat (3) send_byte(8'h00);
    check("t6_active", 8'(active), 8'd0);
    check("t6_strobes", 8'(n_strobe), 8'd0);

    // Randomized: garbage prefix, a COM run of random length, mixed payload
    for (int it = 0; it < 12; it++) begin
      do_reset();
      repeat ($urandom_range(0, 7)) send_bit(1'($urandom_range(0, 1)));
      repeat ($urandom_range(2, 6)) send_byte(C_COM);
      for (int j = 0; j < 16; j++) begin
        sel = int'($urandom_range(0, 5));
        rb  = (sel == 0) ? C_COM : (sel == 1) ? C_IDLE : 8'($urandom);
        send_byte(rb);
      end
      if (it % 3 == 0) begin
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/serial_paralelo.md
Name: serial_paralelo

Overview:
- Serial-to-parallel receiver that sits directly upstream of the two-lane byte demux.
- Deserializes a 1-bit MSB-first stream at clk16f into bytes and finds byte alignment on the COM character.
- Declares the link active after a run of consecutive COMs.
- Presents each byte with a data/valid pair that is held stable for 8 clk16f cycles, i.e. one clk2f period, for the demux to consume.

Parameters:
COM      8'hBC  comma/alignment character
IDLE     8'h7C  idle filler character
BC_LOCK  4      consecutive aligned COMs required to enter ACTIVE (range 2..15)

Ports:
clk16f        input   1  serial bit clock; all state updates on its rising edge
reset         input   1  asynchronous, active-high reset
data_in       input   1  serial data, MSB of each byte first
data_out_c    output  8  deserialized byte
valid_out_c   output  1  high while data_out_c holds a payload byte
active        output  1  high once alignment lock is achieved
byte_strobe   output  1  one-cycle pulse on each cycle that data_out_c is updated

Behaviour:
- Reset (asynchronous, active-high):
  - st=SEARCH; shift register, bit_cnt and bc_cnt cleared.
  - data_out_c=0, valid_out_c=0, active=0, byte_strobe=0.
  - Reset asserted mid-operation aborts immediately; no partial byte is ever emitted.
- Shift register: sr <= {sr[6:0], data_in} every cycle, in every state.
  - The candidate byte is cand = {sr[6:0], data_in}, i.e. the byte completed by the current edge.
- bit_cnt: 3-bit counter, wraps 7->0. A byte boundary is the edge where bit_cnt==7.
- SEARCH: every cycle, compare cand to COM.
  - On match: bit_cnt<=0, bc_cnt<=1, go to ALIGN.
  - Otherwise remain in SEARCH; bit_cnt does not matter.
  - Outputs held at 0; byte_strobe stays 0.
- ALIGN: evaluated at byte boundaries only.
  - cand==COM: bc_cnt<=bc_cnt+1. If bc_cnt+1==BC_LOCK, go to ACTIVE and set active<=1 on the same edge.
  - cand!=COM: bc_cnt<=0, go to SEARCH.
  - No bytes are emitted in this state.
  - A COM match found on a misaligned bit position is ignored here.
- ACTIVE: at each byte boundary:
  - data_out_c<=cand and byte_strobe<=1 for exactly that cycle.
  - valid_out_c<=1 if cand is neither COM nor IDLE; otherwise valid_out_c<=0.
  - Between boundaries, data_out_c and valid_out_c hold their values.
  - ACTIVE is left only by reset; there is no loss-of-lock detection in this revision.
- Latency:
  - A byte's LSB is sampled at edge N; data_out_c/valid_out_c change at edge N.
  - Both are registered and visible after edge N, then stable for 8 cycles.
- The first emitted byte is the one immediately following the BC_LOCK-th COM.
  - With BC_LOCK=4, that is the 5th aligned byte.
- Simultaneous events:
  - A boundary in ALIGN that both reaches BC_LOCK and is a COM sets active=1 only.
  - That COM is not emitted: byte_strobe=0, valid_out_c=0.
- bc_cnt is 4 bits and saturates at BC_LOCK; it never wraps.

Test Plan:
1. Reset, then 3× 0xBC followed by 0x55 -> active stays 0, st returns to SEARCH, no byte_strobe.
2. Reset, 4× 0xBC, then 0x12, 0x34 -> active=1 at the 4th COM's LSB edge; data_out_c=0x12 with valid_out_c=1 eight cycles later, then 0x34; byte_strobe pulses once per byte.
3. Locked stream 0xA5, 0x7C, 0xBC, 0x3C -> data_out_c shows each byte in turn; valid_out_c=1,0,0,1.
4. 3 garbage bits, then 4× 0xBC, then 0xF0 -> lock is achieved on the misaligned stream; data_out_c=0xF0, valid_out_c=1.
5. Assert reset for 2 cycles mid-byte while ACTIVE -> all outputs 0 asynchronously, before the next clock edge; re-lock requires 4 fresh COMs.
6. Stream 0x5E, 0x3F (bit window contains 0xBC mid-boundary: ...01011110 00111111...) -> a SEARCH match at the unaligned position enters ALIGN; the next non-COM boundary returns to SEARCH; active stays 0.
